sram512x8_arb2: RTL and testbench
=================================

Name: sram512x8_arb2

Overview:
Two-requester round-robin arbiter and sequencer for one 512x8 single-port SRAM macro with 8-bit bit-write mask.
- Converts two valid/ready request ports into registered macro controls: CEN, GWEN, WEN, A, D. CEN, GWEN and WEN are active-low.
- Captures Q and routes each read response to the requester that issued it.
- Optionally zero-fills the whole array after reset.
- Sits between core-side bus adapters and the SRAM macro instance.

Parameters:
CLEAR_ON_RESET, 1, 1 = zero-fill all 512 words after reset release; 0 = skip and go straight to RUN.

Ports:
CLK  input  1  rising-edge clock, shared with the macro CLK.
RSTN  input  1  synchronous active-low reset.
P0_VALID  input  1  port 0 request valid.
P0_READY  output  1  port 0 request accepted this cycle.
P0_WE  input  1  1 = write, 0 = read.
P0_WMASK  input  8  active-high per-bit write mask (ignored on reads).
P0_ADDR  input  9  word address.
P0_WDATA  input  8  write data.
P0_RVALID  output  1  one-cycle read-data strobe.
P0_RDATA  output  8  read data; holds its value until the next port-0 read response.
P1_*  (same set as P0_*)  port 1, identical semantics.
BUSY  output  1  high while the clear sequence runs.
SRAM_CEN  output  1  macro chip enable, active-low.
SRAM_GWEN  output  1  macro global write enable, active-low.
SRAM_WEN  output  8  macro bit write enables, active-low.
SRAM_A  output  9  macro address.
SRAM_D  output  8  macro write data.
SRAM_Q  input  8  macro read data.

Behaviour:
- Reset values (RSTN low at an edge):
  - SRAM_CEN=1, SRAM_GWEN=1, SRAM_WEN=8'hFF, SRAM_A=0, SRAM_D=0.
  - P0/P1_RVALID=0, P0/P1_RDATA=0.
  - Clear counter=0, RR pointer=port 0, response pipeline flushed.
  - BUSY = CLEAR_ON_RESET.
  - State = CLEAR if CLEAR_ON_RESET else RUN.
- FSM, state CLEAR:
  - Each cycle registers CEN=0, GWEN=0, WEN=8'h00, D=0, A=counter, then increments counter.
  - After the cycle that issues A=511, state goes to RUN and BUSY falls at that same edge. Total clear = exactly 512 cycles.
  - P0_READY=P1_READY=0 throughout.
- FSM, state RUN:
  - Arbitration is combinational, one grant per cycle.
  - If only one VALID is high, that port gets READY.
  - If both are high, the port named by the RR pointer wins; the pointer then moves to the other port.
  - The pointer only changes on a contested grant. An uncontested grant leaves it unchanged.
  - READY never asserts without VALID.
- Issue: on an accepting edge (VALID & READY) the macro outputs register:
  - CEN=0.
  - GWEN=~WE.
  - WEN = WE ? ~WMASK : 8'hFF.
  - A=ADDR.
  - D = WE ? WDATA : 0.
  - If nothing is accepted: CEN=1, GWEN=1, WEN=8'hFF; A and D hold their previous values.
- Writes with WMASK=0 are still issued (CEN=0, GWEN=0, WEN=FF) and produce no response.
- Read latency:
  - Accept at edge E0; the macro samples at E1; Q is valid after E1.
  - The arbiter registers Q into Pn_RDATA and pulses Pn_RVALID at E2.
  - RVALID is therefore high in the cycle after E2: 2 cycles accept-to-response.
- A 2-stage {valid, port} tag pipeline routes responses. Full throughput: back-to-back reads from either or both ports produce back-to-back RVALIDs in grant order.
- There is no response backpressure. The requester must take RDATA on RVALID or read the held register.
- Read-after-write to the same address on consecutive accepts returns the new data (macro write-then-read ordering); no forwarding logic is added.
- Reset mid-clear restarts the clear from address 0. Reset with reads in flight drops them: no RVALID is emitted after reset.
- Address wrap: none needed, since 9 bits cover exactly 512 words.

Test Plan:
- CLEAR_ON_RESET=1, release RSTN -> BUSY=1 for 512 cycles; macro sees writes to A=0..511 with D=0, WEN=00; P0_READY stays 0 until BUSY=0; a read of A=0x1FF then returns 8'h00.
- P0 writes A=0x055 D=0xA5 WMASK=FF, then reads A=0x055 -> P0_RVALID exactly 2 cycles after the read accept, P0_RDATA=0xA5; P1_RVALID stays 0.
- Masked write: P1 writes A=0x010 D=0xFF WMASK=0x0F over the cleared word -> macro WEN=0xF0; a later read returns 0x0F.
- Both ports hold VALID (reads to 0x001 and 0x002) for 4 cycles -> grants alternate P0,P1,P0,P1; responses alternate with data from 0x001 and 0x002 respectively, one per cycle.
- Only P1 valid for 3 cycles, then both valid -> P1 granted 3 times, then P0 wins the first contested cycle (pointer unchanged by uncontested grants).
- Assert RSTN low for 1 cycle during a read in flight and also at clear count 200 -> no stray RVALID; clear restarts at A=0 and runs a full 512 cycles.

Source files
------------

// File: rtl/sram512x8_arb2.sv
// Two-port round-robin arbiter and sequencer for a 512x8 single-port SRAM
// macro with bit-write mask. Macro controls are registered; read responses
// are steered back to the issuing port by a two-stage tag pipeline.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | zero-filling words 0..511, one per cycle, ports held off
// ST_RUN   | normal operation, one grant per cycle, round-robin on contention

module sram512x8_arb2 #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       P0_VALID,
    output logic       P0_READY,
    input  logic       P0_WE,
    input  logic [7:0] P0_WMASK,
    input  logic [8:0] P0_ADDR,
    input  logic [7:0] P0_WDATA,
    output logic       P0_RVALID,
    output logic [7:0] P0_RDATA,
    input  logic       P1_VALID,
    output logic       P1_READY,
    input  logic       P1_WE,
    input  logic [7:0] P1_WMASK,
    input  logic [8:0] P1_ADDR,
    input  logic [7:0] P1_WDATA,
    output logic       P1_RVALID,
    output logic [7:0] P1_RDATA,
    output logic       BUSY,
    output logic       SRAM_CEN,
    output logic       SRAM_GWEN,
    output logic [7:0] SRAM_WEN,
    output logic [8:0] SRAM_A,
    output logic [7:0] SRAM_D,
    input  logic [7:0] SRAM_Q
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [8:0] clr_cnt, clr_cnt_nx;
    logic       rr_ptr, rr_ptr_nx;
    logic       gnt0, gnt1;
    logic       cen_nx, gwen_nx;
    logic [7:0] wen_nx, d_nx;
    logic [8:0] a_nx;
    logic       tag1_v, tag1_p, tag1_v_nx, tag1_p_nx;
    logic       tag2_v, tag2_p;

    assign P0_READY = gnt0;
    assign P1_READY = gnt1;
    assign BUSY     = (state == ST_CLEAR);

    // Next-state, arbitration and next macro controls.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        rr_ptr_nx  = rr_ptr;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        cen_nx     = 1'b1;
        gwen_nx    = 1'b1;
        wen_nx     = 8'hFF;
        a_nx       = SRAM_A;
        d_nx       = SRAM_D;
        tag1_v_nx  = 1'b0;
        tag1_p_nx  = 1'b0;
        case (state)
            ST_CLEAR: begin
                cen_nx     = 1'b0;
                gwen_nx    = 1'b0;
                wen_nx     = 8'h00;
                a_nx       = clr_cnt;
                d_nx       = 8'h00;
                clr_cnt_nx = clr_cnt + 9'd1;
                if (clr_cnt == 9'd511) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (P0_VALID && P1_VALID) begin
                    // Contested: pointer names the winner, then hands over.
                    gnt0      = ~rr_ptr;
                    gnt1      = rr_ptr;
                    rr_ptr_nx = ~rr_ptr;
                end else begin
                    gnt0 = P0_VALID;
                    gnt1 = P1_VALID;
                end
                if (gnt0) begin
                    cen_nx    = 1'b0;
                    gwen_nx   = ~P0_WE;
                    wen_nx    = P0_WE ? ~P0_WMASK : 8'hFF;
                    a_nx      = P0_ADDR;
                    d_nx      = P0_WE ? P0_WDATA : 8'h00;
                    tag1_v_nx = ~P0_WE;
                    tag1_p_nx = 1'b0;
                end else if (gnt1) begin
                    cen_nx    = 1'b0;
                    gwen_nx   = ~P1_WE;
                    wen_nx    = P1_WE ? ~P1_WMASK : 8'hFF;
                    a_nx      = P1_ADDR;
                    d_nx      = P1_WE ? P1_WDATA : 8'h00;
                    tag1_v_nx = ~P1_WE;
                    tag1_p_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // State register, clear counter, pointer and registered macro controls.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt   <= 9'd0;
            rr_ptr    <= 1'b0;
            SRAM_CEN  <= 1'b1;
            SRAM_GWEN <= 1'b1;
            SRAM_WEN  <= 8'hFF;
            SRAM_A    <= 9'd0;
            SRAM_D    <= 8'h00;
        end else begin
            state     <= state_nx;
            clr_cnt   <= clr_cnt_nx;
            rr_ptr    <= rr_ptr_nx;
            SRAM_CEN  <= cen_nx;
            SRAM_GWEN <= gwen_nx;
            SRAM_WEN  <= wen_nx;
            SRAM_A    <= a_nx;
            SRAM_D    <= d_nx;
        end
    end

    // Tag pipeline: stage 1 at issue, stage 2 while the macro reads,
    // then Q is captured into the owning port's data register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            tag1_v    <= 1'b0;
            tag1_p    <= 1'b0;
            tag2_v    <= 1'b0;
            tag2_p    <= 1'b0;
            P0_RVALID <= 1'b0;
            P1_RVALID <= 1'b0;
            P0_RDATA  <= 8'h00;
            P1_RDATA  <= 8'h00;
        end else begin
            tag1_v    <= tag1_v_nx;
            tag1_p    <= tag1_p_nx;
            tag2_v    <= tag1_v;
            tag2_p    <= tag1_p;
            P0_RVALID <= tag2_v & ~tag2_p;
            P1_RVALID <= tag2_v & tag2_p;
            if (tag2_v && !tag2_p) begin
                P0_RDATA <= SRAM_Q;
            end
            if (tag2_v && tag2_p) begin
                P1_RDATA <= SRAM_Q;
            end
        end
    end

endmodule

// File: tb/tb_sram512x8_arb2.sv
// Bench for sram512x8_arb2: behavioural SRAM macro plus a transaction-level
// reference (memory array, grant pointer, queue of due responses).
module tb_sram512x8_arb2;

    logic       clk;
    logic       rstn;
    logic       p0_valid, p0_we, p1_valid, p1_we;
    logic [7:0] p0_wmask, p0_wdata, p1_wmask, p1_wdata;
    logic [8:0] p0_addr, p1_addr;
    logic       p0_ready, p1_ready, p0_rvalid, p1_rvalid, busy;
    logic [7:0] p0_rdata, p1_rdata;
    logic       sram_cen, sram_gwen;
    logic [7:0] sram_wen, sram_d, sram_q;
    logic [8:0] sram_a;

    sram512x8_arb2 #(.CLEAR_ON_RESET(1'b1)) dut (
        .CLK(clk), .RSTN(rstn),
        .P0_VALID(p0_valid), .P0_READY(p0_ready), .P0_WE(p0_we), .P0_WMASK(p0_wmask),
        .P0_ADDR(p0_addr), .P0_WDATA(p0_wdata), .P0_RVALID(p0_rvalid), .P0_RDATA(p0_rdata),
        .P1_VALID(p1_valid), .P1_READY(p1_ready), .P1_WE(p1_we), .P1_WMASK(p1_wmask),
        .P1_ADDR(p1_addr), .P1_WDATA(p1_wdata), .P1_RVALID(p1_rvalid), .P1_RDATA(p1_rdata),
        .BUSY(busy), .SRAM_CEN(sram_cen), .SRAM_GWEN(sram_gwen), .SRAM_WEN(sram_wen),
        .SRAM_A(sram_a), .SRAM_D(sram_d), .SRAM_Q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro: write-then-read ordering, one access per edge.
    logic [7:0] macro_mem [512];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= macro_mem[sram_a];
        end
    end

    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    logic [7:0] mem_ref [512];
    logic       m_run, m_rr;
    logic [8:0] m_a;
    logic [7:0] m_d, exp_rd0, exp_rd1;
    int         q_due [$];
    logic       q_port [$];
    logic [7:0] q_data [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_valid = 1'b0; p0_we = 1'b0; p0_wmask = 8'h00; p0_addr = 9'd0; p0_wdata = 8'h00;
        p1_valid = 1'b0; p1_we = 1'b0; p1_wmask = 8'h00; p1_addr = 9'd0; p1_wdata = 8'h00;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_rr = 1'b0;
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        q_due.delete(); q_port.delete(); q_data.delete();
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [8:0] a,
                          input logic [7:0] wd, input logic [7:0] wm);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = wd; p0_wmask = wm;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [8:0] a,
                          input logic [7:0] wd, input logic [7:0] wm);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = wd; p1_wmask = wm;
    endtask

    // One edge of RSTN low, then check the reset values.
    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("rst_cen",    16'(sram_cen),  16'(1'b1));
        check("rst_gwen",   16'(sram_gwen), 16'(1'b1));
        check("rst_wen",    16'(sram_wen),  16'(8'hFF));
        check("rst_a",      16'(sram_a),    16'(9'd0));
        check("rst_d",      16'(sram_d),    16'(8'h00));
        check("rst_rvalid0",16'(p0_rvalid), 16'(1'b0));
        check("rst_rvalid1",16'(p1_rvalid), 16'(1'b0));
        check("rst_rdata0", 16'(p0_rdata),  16'(8'h00));
        check("rst_rdata1", 16'(p1_rdata),  16'(8'h00));
        check("rst_busy",   16'(busy),      16'(1'b1));
        rstn = 1'b1;
    endtask

    // Walk the zero-fill; optionally pulse reset at clear count abort_at.
    task automatic run_clear(input int abort_at);
        for (int k = 0; k < 512; k++) begin
            #1;
            check("clr_ready0", 16'(p0_ready), 16'(1'b0));
            check("clr_ready1", 16'(p1_ready), 16'(1'b0));
            if (k == abort_at) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                check("abort_cen",  16'(sram_cen), 16'(1'b1));
                check("abort_a",    16'(sram_a),   16'(9'd0));
                check("abort_busy", 16'(busy),     16'(1'b1));
                rstn = 1'b1;
                return;
            end
            @(posedge clk); #1;
            check("clr_a",    16'(sram_a),    16'(k));
            check("clr_cen",  16'(sram_cen),  16'(1'b0));
            check("clr_gwen", 16'(sram_gwen), 16'(1'b0));
            check("clr_wen",  16'(sram_wen),  16'(8'h00));
            check("clr_d",    16'(sram_d),    16'(8'h00));
            check("clr_busy", 16'(busy),      16'(k != 511));
            check("clr_rv0",  16'(p0_rvalid), 16'(1'b0));
            check("clr_rv1",  16'(p1_rvalid), 16'(1'b0));
        end
        m_run = 1'b1; m_a = 9'd511; m_d = 8'h00;
        for (int i = 0; i < 512; i++) mem_ref[i] = 8'h00;
    endtask

    // One RUN cycle: predict grant, check READY, clock, check macro and responses.
    task automatic cyc();
        logic       g0, g1, we, e0v, e1v, e_cen, e_gwen;
        logic [8:0] a;
        logic [7:0] wd, wm, e_wen;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (p0_valid && p1_valid) begin
            if (!m_rr) g0 = 1'b1; else g1 = 1'b1;
            m_rr = !m_rr;
        end else begin
            g0 = p0_valid; g1 = p1_valid;
        end
        check("ready0", 16'(p0_ready), 16'(g0));
        check("ready1", 16'(p1_ready), 16'(g1));
        @(posedge clk); #1;
        cycle++;
        e_cen = 1'b1; e_gwen = 1'b1; e_wen = 8'hFF;
        if (g0 || g1) begin
            we = g0 ? p0_we    : p1_we;
            a  = g0 ? p0_addr  : p1_addr;
            wd = g0 ? p0_wdata : p1_wdata;
            wm = g0 ? p0_wmask : p1_wmask;
            e_cen = 1'b0; e_gwen = !we; e_wen = we ? ~wm : 8'hFF;
            m_a = a; m_d = we ? wd : 8'h00;
            if (we) mem_ref[a] = (mem_ref[a] & ~wm) | (wd & wm);
            else begin
                q_due.push_back(cycle + 2); q_port.push_back(g1); q_data.push_back(mem_ref[a]);
            end
        end
        check("cen",  16'(sram_cen),  16'(e_cen));
        check("gwen", 16'(sram_gwen), 16'(e_gwen));
        check("wen",  16'(sram_wen),  16'(e_wen));
        check("a",    16'(sram_a),    16'(m_a));
        check("d",    16'(sram_d),    16'(m_d));
        e0v = 1'b0; e1v = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cycle) begin
            if (q_port[0]) begin e1v = 1'b1; exp_rd1 = q_data[0]; end
            else begin e0v = 1'b1; exp_rd0 = q_data[0]; end
            void'(q_due.pop_front()); void'(q_port.pop_front()); void'(q_data.pop_front());
        end
        check("rvalid0", 16'(p0_rvalid), 16'(e0v));
        check("rvalid1", 16'(p1_rvalid), 16'(e1v));
        check("rdata0",  16'(p0_rdata),  16'(exp_rd0));
        check("rdata1",  16'(p1_rdata),  16'(exp_rd1));
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) macro_mem[i] = 8'($urandom());
        sram_q = 8'h00;
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Full clear with a port-0 read of 0x1FF pending throughout.
        set_p0(1'b1, 1'b0, 9'h1FF, 8'h00, 8'h00);
        run_clear(-1);
        cyc();
        idle_cycles(3);

        // Full-mask write then read back on port 0.
        set_p0(1'b1, 1'b1, 9'h055, 8'hA5, 8'hFF); cyc();
        set_p0(1'b1, 1'b0, 9'h055, 8'h00, 8'h00); cyc();
        idle_cycles(3);

        // Zero-mask write is issued but changes nothing.
        set_p0(1'b1, 1'b1, 9'h055, 8'h3C, 8'h00); cyc();
        set_p0(1'b1, 1'b0, 9'h055, 8'h00, 8'h00); cyc();
        idle_cycles(3);

        // Masked write from port 1 over a cleared word.
        set_p1(1'b1, 1'b1, 9'h010, 8'hFF, 8'h0F); cyc();
        idle_cycles(1);
        set_p1(1'b1, 1'b0, 9'h010, 8'h00, 8'h00); cyc();
        idle_cycles(3);

        // Contested reads of 0x001/0x002 for four cycles.
        set_p0(1'b1, 1'b1, 9'h001, 8'h11, 8'hFF); cyc();
        idle_inputs();
        set_p1(1'b1, 1'b1, 9'h002, 8'h22, 8'hFF); cyc();
        set_p0(1'b1, 1'b0, 9'h001, 8'h00, 8'h00);
        set_p1(1'b1, 1'b0, 9'h002, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) cyc();
        idle_cycles(3);

        // Uncontested port-1 grants leave the pointer alone.
        set_p1(1'b1, 1'b0, 9'h010, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cyc();
        set_p0(1'b1, 1'b0, 9'h055, 8'h00, 8'h00);
        cyc();
        idle_cycles(3);

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            set_p0(1'($urandom()), 1'($urandom()), 9'($urandom()), 8'($urandom()), 8'($urandom()));
            set_p1(1'($urandom()), 1'($urandom()), 9'($urandom()), 8'($urandom()), 8'($urandom()));
            cyc();
        end
        idle_cycles(3);

        // Reset with a read in flight, then reset mid-clear at count 200.
        set_p0(1'b1, 1'b0, 9'h055, 8'h00, 8'h00); cyc();
        do_reset();
        run_clear(200);
        model_reset();
        run_clear(-1);
        set_p0(1'b1, 1'b0, 9'h055, 8'h00, 8'h00); cyc();
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
